test_result_monitor: RTL and testbench

- Sits directly downstream of the CI self-checking test wrappers, e.g. the 8-bit subtract test.
- Sequences a batch of up to NUM_TESTS wrappers: holds them in reset, releases them, then captures each wrapper's sticky fail/finish outputs.
- Enforces a cycle timeout and produces one aggregated pass/fail verdict for the simulation top to report and exit on.

---
 rtl/test_result_monitor.sv | 168 ++++++++++++++++
 tb/tb_test_result_monitor.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/test_result_monitor.sv
// test_result_monitor
// Sequences a batch of self-checking test wrappers: holds them in reset,
// releases them, captures their sticky fail/finish flags, enforces a cycle
// budget and registers one aggregated pass/fail verdict.
// Optional feature macro: TEST_RESULT_MONITOR_FIRST_FAIL_EN adds a record of
// the first failing test (index and cycle).
module test_result_monitor #(
  parameter int NUM_TESTS      = 8,
  parameter int RESET_CYCLES   = 4,
  parameter int TIMEOUT_CYCLES = 1000,
  parameter int CNT_W          = 32,
  localparam int IDX_W         = (NUM_TESTS > 1) ? $clog2(NUM_TESTS) : 1
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 start,
  input  logic [NUM_TESTS-1:0] test_fail,
  input  logic [NUM_TESTS-1:0] test_finish,
  output logic                 test_reset,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic                 timeout,
  output logic [NUM_TESTS-1:0] fail_mask,
  output logic [NUM_TESTS-1:0] finish_mask,
`ifdef TEST_RESULT_MONITOR_FIRST_FAIL_EN
  output logic                 first_fail_valid,
  output logic [IDX_W-1:0]     first_fail_idx,
  output logic [CNT_W-1:0]     first_fail_cycle,
`endif
  output logic [CNT_W-1:0]     cycle_count
);

  localparam int RST_W = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_RESET_DUT = 2'd1,
    ST_RUN       = 2'd2,
    ST_DONE      = 2'd3
  } state_t;

  state_t               state_r;
  state_t               state_nxt_s;
  logic [RST_W-1:0]     rst_cnt_r;
  logic [NUM_TESTS-1:0] clean_fail_s;
  logic [NUM_TESTS-1:0] clean_finish_s;
  logic [NUM_TESTS-1:0] next_fail_s;
  logic [NUM_TESTS-1:0] next_finish_s;
  logic                 all_fin_s;
  logic                 at_limit_s;
`ifdef TEST_RESULT_MONITOR_FIRST_FAIL_EN
  logic [IDX_W-1:0]     ff_idx_s;
`endif

  // Input cleanup (X/Z counts as 0) and next-value capture terms
  always_comb begin
    clean_fail_s   = {NUM_TESTS{1'b0}};
    clean_finish_s = {NUM_TESTS{1'b0}};
    for (int i = 0; i < NUM_TESTS; i++) begin
      clean_fail_s[i]   = (test_fail[i] === 1'b1);
      clean_finish_s[i] = (test_finish[i] === 1'b1);
    end
    next_fail_s   = fail_mask | clean_fail_s;
    next_finish_s = finish_mask | clean_finish_s;
    all_fin_s     = &next_finish_s;
    at_limit_s    = (cycle_count == CNT_W'(TIMEOUT_CYCLES - 1));
  end

`ifdef TEST_RESULT_MONITOR_FIRST_FAIL_EN
  // Lowest-index failing test on the current cycle
  always_comb begin
    ff_idx_s = {IDX_W{1'b0}};
    for (int i = NUM_TESTS - 1; i >= 0; i--) begin
      ff_idx_s = clean_fail_s[i] ? IDX_W'(i) : ff_idx_s;
    end
  end
`endif

  // Next-state decode; completion is checked before the budget so it wins a tie
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start) state_nxt_s = ST_RESET_DUT;
        else       state_nxt_s = ST_IDLE;
      end
      ST_RESET_DUT: begin
        if (rst_cnt_r == RST_W'(0)) state_nxt_s = ST_RUN;
        else                        state_nxt_s = ST_RESET_DUT;
      end
      ST_RUN: begin
        if (all_fin_s)       state_nxt_s = ST_DONE;
        else if (at_limit_s) state_nxt_s = ST_DONE;
        else                 state_nxt_s = ST_RUN;
      end
      ST_DONE: begin
        if (start) state_nxt_s = ST_RESET_DUT;
        else       state_nxt_s = ST_DONE;
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // State, registered outputs, capture masks and cycle counter
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r     <= ST_IDLE;
      rst_cnt_r   <= RST_W'(0);
      test_reset  <= 1'b1;
      busy        <= 1'b0;
      done        <= 1'b0;
      pass        <= 1'b0;
      timeout     <= 1'b0;
      fail_mask   <= {NUM_TESTS{1'b0}};
      finish_mask <= {NUM_TESTS{1'b0}};
      cycle_count <= {CNT_W{1'b0}};
`ifdef TEST_RESULT_MONITOR_FIRST_FAIL_EN
      first_fail_valid <= 1'b0;
      first_fail_idx   <= {IDX_W{1'b0}};
      first_fail_cycle <= {CNT_W{1'b0}};
`endif
    end else begin
      state_r    <= state_nxt_s;
      test_reset <= (state_nxt_s != ST_RUN);
      busy       <= (state_nxt_s == ST_RESET_DUT) || (state_nxt_s == ST_RUN);
      done       <= (state_nxt_s == ST_DONE);
      case (state_r)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            rst_cnt_r   <= RST_W'(RESET_CYCLES - 1);
            pass        <= 1'b0;
            timeout     <= 1'b0;
            fail_mask   <= {NUM_TESTS{1'b0}};
            finish_mask <= {NUM_TESTS{1'b0}};
            cycle_count <= {CNT_W{1'b0}};
`ifdef TEST_RESULT_MONITOR_FIRST_FAIL_EN
            first_fail_valid <= 1'b0;
            first_fail_idx   <= {IDX_W{1'b0}};
            first_fail_cycle <= {CNT_W{1'b0}};
`endif
          end
        end
        ST_RESET_DUT: begin
          if (rst_cnt_r != RST_W'(0)) rst_cnt_r <= rst_cnt_r - RST_W'(1);
        end
        ST_RUN: begin
          fail_mask   <= next_fail_s;
          finish_mask <= next_finish_s;
          if (cycle_count != {CNT_W{1'b1}}) cycle_count <= cycle_count + CNT_W'(1);
          if (!all_fin_s && at_limit_s) timeout <= 1'b1;
          if (state_nxt_s == ST_DONE) pass <= all_fin_s && (next_fail_s == {NUM_TESTS{1'b0}});
`ifdef TEST_RESULT_MONITOR_FIRST_FAIL_EN
          if (!first_fail_valid && (|clean_fail_s)) begin
            first_fail_valid <= 1'b1;
            first_fail_idx   <= ff_idx_s;
            first_fail_cycle <= cycle_count;
          end
`endif
        end
        default: begin
          rst_cnt_r <= RST_W'(0);
        end
      endcase
    end
  end

endmodule

// File: tb/tb_test_result_monitor.sv
// Self-checking bench for test_result_monitor (NUM_TESTS=2, RESET_CYCLES=4,
// TIMEOUT_CYCLES=10). Expected results come from a run-level model: each
// wrapper is described by the RUN cycle its finish/fail flag rises, and the
// verdict is derived from those arrival cycles.
module tb_test_result_monitor;

  localparam int NT    = 2;
  localparam int RC    = 4;
  localparam int TO    = 10;
  localparam int CW    = 32;
  localparam int NEVER = 100000;

  logic          clock;
  logic          reset;
  logic          start;
  logic [NT-1:0] test_fail;
  logic [NT-1:0] test_finish;
  logic          test_reset;
  logic          busy;
  logic          done;
  logic          pass;
  logic          timeout;
  logic [NT-1:0] fail_mask;
  logic [NT-1:0] finish_mask;
  logic [CW-1:0] cycle_count;
`ifdef TEST_RESULT_MONITOR_FIRST_FAIL_EN
  logic          first_fail_valid;
  logic [0:0]    first_fail_idx;
  logic [CW-1:0] first_fail_cycle;
`endif

  int checks = 0;
  int fails  = 0;

  test_result_monitor #(
    .NUM_TESTS(NT), .RESET_CYCLES(RC), .TIMEOUT_CYCLES(TO), .CNT_W(CW)
  ) dut (
    .clock(clock), .reset(reset), .start(start),
    .test_fail(test_fail), .test_finish(test_finish),
    .test_reset(test_reset), .busy(busy), .done(done), .pass(pass),
    .timeout(timeout), .fail_mask(fail_mask), .finish_mask(finish_mask),
`ifdef TEST_RESULT_MONITOR_FIRST_FAIL_EN
    .first_fail_valid(first_fail_valid), .first_fail_idx(first_fail_idx),
    .first_fail_cycle(first_fail_cycle),
`endif
    .cycle_count(cycle_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // One full run: fin/fail give the RUN cycle each flag rises (NEVER = not at all),
  // start_cyc places an extra start pulse that must be ignored, xin drives X on idle fail bits.
  task automatic run_scenario(input string name, input int fin0, input int fin1,
                              input int fail0, input int fail1, input int start_cyc, input bit xin);
    int fin [NT];
    int fl  [NT];
    int last_fin, exp_exit, exp_ff_cyc, exp_ff_idx, c, n;
    bit exp_to, exp_pass, seen;
    logic [NT-1:0] exp_fm, exp_nm;
    fin[0] = fin0; fin[1] = fin1; fl[0] = fail0; fl[1] = fail1;
    // model: run ends at the last finish if it lands within budget, else at the budget edge
    last_fin = 0;
    for (int i = 0; i < NT; i++) if (fin[i] > last_fin) last_fin = fin[i];
    if (last_fin <= TO - 1) begin exp_exit = last_fin; exp_to = 1'b0; end
    else begin exp_exit = TO - 1; exp_to = 1'b1; end
    exp_fm = '0; exp_nm = '0; exp_ff_cyc = NEVER; exp_ff_idx = 0;
    for (int i = 0; i < NT; i++) begin
      exp_fm[i] = (fl[i] <= exp_exit);
      exp_nm[i] = (fin[i] <= exp_exit);
      if (fl[i] <= exp_exit && fl[i] < exp_ff_cyc) begin exp_ff_cyc = fl[i]; exp_ff_idx = i; end
    end
    exp_pass = !exp_to && (exp_fm == '0);

    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    checks++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      fails++; $display("FAIL %s busy_after_start: got busy=%b done=%b expected 1 0", name, busy, done);
    end
    n = 0;
    while (test_reset === 1'b1 && n < 20) begin
      n++;
      if (n == 2) start = 1'b1;
      @(posedge clock); #1;
      start = 1'b0;
    end
    checks++;
    if (n != RC) begin
      fails++; $display("FAIL %s reset_hold: got %0d cycles expected %0d", name, n, RC);
    end
    c = 0; seen = 1'b0;
    while (!seen && c < 40) begin
      for (int i = 0; i < NT; i++) begin
        test_finish[i] = (c >= fin[i]);
        test_fail[i]   = (c >= fl[i]) ? 1'b1 : (xin ? 1'bx : 1'b0);
      end
      start = (c == start_cyc);
      @(posedge clock); #1;
      start = 1'b0;
      if (done === 1'b1) seen = 1'b1;
      else c++;
    end
    test_fail = '0; test_finish = '0;
    checks++;
    if (!seen || c != exp_exit) begin
      fails++; $display("FAIL %s exit_cycle: got %0d (seen=%0d) expected %0d", name, c, seen, exp_exit);
    end
    checks++;
    if (pass !== exp_pass || timeout !== exp_to || busy !== 1'b0 || test_reset !== 1'b1) begin
      fails++;
      $display("FAIL %s verdict: got pass=%b timeout=%b busy=%b test_reset=%b expected %b %b 0 1",
               name, pass, timeout, busy, test_reset, exp_pass, exp_to);
    end
    checks++;
    if (fail_mask !== exp_fm || finish_mask !== exp_nm) begin
      fails++;
      $display("FAIL %s masks: got fail=%b finish=%b expected %b %b", name, fail_mask, finish_mask, exp_fm, exp_nm);
    end
    checks++;
    if (cycle_count !== 32'(exp_exit + 1)) begin
      fails++; $display("FAIL %s cycle_count: got %0d expected %0d", name, cycle_count, exp_exit + 1);
    end
`ifdef TEST_RESULT_MONITOR_FIRST_FAIL_EN
    checks++;
    if (first_fail_valid !== (exp_ff_cyc != NEVER) ||
        (exp_ff_cyc != NEVER && (first_fail_idx !== 1'(exp_ff_idx) || first_fail_cycle !== 32'(exp_ff_cyc)))) begin
      fails++;
      $display("FAIL %s first_fail: got v=%b idx=%0d cyc=%0d expected v=%0d idx=%0d cyc=%0d", name,
               first_fail_valid, first_fail_idx, first_fail_cycle, exp_ff_cyc != NEVER, exp_ff_idx, exp_ff_cyc);
    end
`endif
  endtask

  task automatic test_reset_state();
    reset = 1'b0; start = 1'b0; test_fail = '0; test_finish = '0;
    #12;
    checks++;
    if (test_reset !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || pass !== 1'b0 || timeout !== 1'b0) begin
      fails++;
      $display("FAIL reset_flags: got tr=%b busy=%b done=%b pass=%b to=%b expected 1 0 0 0 0",
               test_reset, busy, done, pass, timeout);
    end
    checks++;
    if (fail_mask !== '0 || finish_mask !== '0 || cycle_count !== '0) begin
      fails++; $display("FAIL reset_values: got fm=%b nm=%b cc=%0d expected 0 0 0", fail_mask, finish_mask, cycle_count);
    end
    reset = 1'b1;
    test_fail = 2'b11; test_finish = 2'b11;
    repeat (3) @(posedge clock);
    #1;
    test_fail = '0; test_finish = '0;
    checks++;
    if (test_reset !== 1'b1 || done !== 1'b0 || finish_mask !== '0) begin
      fails++; $display("FAIL idle_hold: got tr=%b done=%b nm=%b expected 1 0 00", test_reset, done, finish_mask);
    end
  endtask

  task automatic test_directed();
    run_scenario("basic_pass", 3, 3, NEVER, NEVER, -1, 1'b0);
    @(posedge clock); #1;
    checks++;
    if (done !== 1'b1 || cycle_count !== 32'd4 || finish_mask !== 2'b11) begin
      fails++; $display("FAIL done_hold: got done=%b cc=%0d nm=%b expected 1 4 11", done, cycle_count, finish_mask);
    end
    run_scenario("fail_t1", 5, 5, NEVER, 2, -1, 1'b0);
    run_scenario("timeout", 1, NEVER, NEVER, NEVER, -1, 1'b0);
    run_scenario("finish_on_limit", 4, 9, NEVER, NEVER, -1, 1'b0);
    run_scenario("fail_on_exit", 6, 6, 6, NEVER, -1, 1'b0);
    run_scenario("x_fail_inputs", 2, 5, NEVER, NEVER, -1, 1'b1);
  endtask

  task automatic test_midrun_reset();
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    repeat (RC) @(posedge clock);
    #1;
    test_fail = 2'b01; test_finish = 2'b01;
    repeat (3) @(posedge clock);
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if (test_reset !== 1'b1 || busy !== 1'b0 || cycle_count !== '0 || fail_mask !== '0 || finish_mask !== '0) begin
      fails++;
      $display("FAIL async_abort: got tr=%b busy=%b cc=%0d fm=%b nm=%b expected 1 0 0 00 00",
               test_reset, busy, cycle_count, fail_mask, finish_mask);
    end
    test_fail = '0; test_finish = '0;
    #3;
    reset = 1'b1;
    @(posedge clock); #1;
    run_scenario("after_abort", 2, 2, NEVER, NEVER, -1, 1'b0);
  endtask

  task automatic test_back_to_back();
    run_scenario("restart_a", 2, 2, 1, NEVER, -1, 1'b0);
    run_scenario("restart_b", 3, 1, NEVER, NEVER, -1, 1'b0);
    run_scenario("start_ignored", 7, 7, NEVER, NEVER, 4, 1'b0);
  endtask

  task automatic test_random();
    int f0, f1, l0, l1, sc;
    bit xi;
    for (int k = 0; k < 20; k++) begin
      f0 = $urandom_range(0, 12); f1 = $urandom_range(0, 12);
      if (f0 > 11) f0 = NEVER;
      l0 = $urandom_range(0, 15); l1 = $urandom_range(0, 15);
      if (l0 > 10) l0 = NEVER;
      if (l1 > 10) l1 = NEVER;
      sc = $urandom_range(0, 3) == 0 ? -1 : int'($urandom_range(0, 9));
      xi = 1'($urandom_range(0, 1));
      run_scenario($sformatf("rand%0d", k), f0, f1, l0, l1, sc, xi);
    end
  endtask

  initial begin
    test_reset_state();
    test_directed();
    test_midrun_reset();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
